// File: rtl/param_reg_file.sv
// param_reg_file: NUM_REGS x DATA_W register file with two combinational read
// ports, one write port, and a pending (scoreboard) bit per register.
// A claim marks a register as awaiting a producer. A later write clears the
// bit, unless a claim to the same register lands in that cycle.
module param_reg_file #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 4,
    parameter int ZERO_REG = 0,
    parameter int BYPASS   = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic [ADDR_W-1:0]        rd_addr1,
    output logic [DATA_W-1:0]        rd_data1,
    input  logic [ADDR_W-1:0]        rd_addr2,
    output logic [DATA_W-1:0]        rd_data2,
    input  logic                     claim_en,
    input  logic [ADDR_W-1:0]        claim_addr,
    output logic                     busy1,
    output logic                     busy2,
    output logic [(2**ADDR_W)-1:0]   busy_vec
);

    localparam int NUM_REGS = 2**ADDR_W;

    logic [DATA_W-1:0]   regs_q [NUM_REGS];
    logic [DATA_W-1:0]   regs_d [NUM_REGS];
    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;

    // Next-state for storage and pending bits. The claim is applied after the write, so it wins.
    always_comb begin
        regs_d = regs_q;
        busy_d = busy_q;
        if (wr_en) begin
            regs_d[wr_addr] = wr_data;
            busy_d[wr_addr] = 1'b0;
        end
        if (claim_en) begin
            busy_d[claim_addr] = 1'b1;
        end
        if (ZERO_REG != 0) begin
            regs_d[0] = '0;
            busy_d[0] = 1'b0;
        end
    end

    // State registers. Reset clears data and pending bits without waiting for a clock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
            busy_q <= '0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
        end
    end

    assign busy_vec = busy_q;

    // Read port 1: reset masking, hardwired zero register, then write forwarding, then storage.
    always_comb begin
        rd_data1 = regs_q[rd_addr1];
        busy1    = busy_q[rd_addr1];
        if (rst) begin
            rd_data1 = '0;
            busy1    = 1'b0;
        end else if ((ZERO_REG != 0) && (rd_addr1 == '0)) begin
            rd_data1 = '0;
            busy1    = 1'b0;
        end else if ((BYPASS != 0) && wr_en && (wr_addr == rd_addr1)) begin
            rd_data1 = wr_data;
            busy1    = 1'b0;
        end
    end

    // Read port 2: same priority as port 1.
    always_comb begin
        rd_data2 = regs_q[rd_addr2];
        busy2    = busy_q[rd_addr2];
        if (rst) begin
            rd_data2 = '0;
            busy2    = 1'b0;
        end else if ((ZERO_REG != 0) && (rd_addr2 == '0)) begin
            rd_data2 = '0;
            busy2    = 1'b0;
        end else if ((BYPASS != 0) && wr_en && (wr_addr == rd_addr2)) begin
            rd_data2 = wr_data;
            busy2    = 1'b0;
        end
    end

endmodule

// File: tb/tb_param_reg_file.sv
// Bench for param_reg_file. Three instances share one stimulus stream:
// d0 has bypass on, d1 has bypass off, and d2 has the zero register and bypass on.
// The stimulus pushes expected values into a queue. A monitor pops them and checks them on the falling edge.
module tb_param_reg_file;

    localparam int RD1 = 0, RD2 = 1, B1 = 2, B2 = 3, BV = 4;
    localparam int D0 = 0, D1 = 8, D2 = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_en = 1'b0;
    logic [3:0]  wr_addr = '0;
    logic [15:0] wr_data = '0;
    logic [3:0]  rd_addr1 = '0;
    logic [3:0]  rd_addr2 = '0;
    logic        claim_en = 1'b0;
    logic [3:0]  claim_addr = '0;

    logic [15:0] rd1_0, rd2_0, rd1_1, rd2_1, rd1_2, rd2_2;
    logic        b1_0, b2_0, b1_1, b2_1, b1_2, b2_2;
    logic [15:0] bv_0, bv_1, bv_2;

    param_reg_file #(.DATA_W(16), .ADDR_W(4), .ZERO_REG(0), .BYPASS(1)) d0 (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr1(rd_addr1), .rd_data1(rd1_0), .rd_addr2(rd_addr2), .rd_data2(rd2_0),
        .claim_en(claim_en), .claim_addr(claim_addr), .busy1(b1_0), .busy2(b2_0),
        .busy_vec(bv_0));

    param_reg_file #(.DATA_W(16), .ADDR_W(4), .ZERO_REG(0), .BYPASS(0)) d1 (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr1(rd_addr1), .rd_data1(rd1_1), .rd_addr2(rd_addr2), .rd_data2(rd2_1),
        .claim_en(claim_en), .claim_addr(claim_addr), .busy1(b1_1), .busy2(b2_1),
        .busy_vec(bv_1));

    param_reg_file #(.DATA_W(16), .ADDR_W(4), .ZERO_REG(1), .BYPASS(1)) d2 (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr1(rd_addr1), .rd_data1(rd1_2), .rd_addr2(rd_addr2), .rd_data2(rd2_2),
        .claim_en(claim_en), .claim_addr(claim_addr), .busy1(b1_2), .busy2(b2_2),
        .busy_vec(bv_2));

    always #5 clk = ~clk;

    int cyc_cnt = 0;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    typedef struct {
        int          cyc;
        int          sel;
        logic [31:0] exp;
        string       name;
    } sb_entry_t;

    sb_entry_t sb[$];
    int checks = 0;
    int errors = 0;

    function automatic logic [31:0] get_actual(input int sel);
        case (sel)
            D0+RD1: return {16'h0, rd1_0};
            D0+RD2: return {16'h0, rd2_0};
            D0+B1:  return {31'h0, b1_0};
            D0+B2:  return {31'h0, b2_0};
            D0+BV:  return {16'h0, bv_0};
            D1+RD1: return {16'h0, rd1_1};
            D1+RD2: return {16'h0, rd2_1};
            D1+B1:  return {31'h0, b1_1};
            D1+B2:  return {31'h0, b2_1};
            D1+BV:  return {16'h0, bv_1};
            D2+RD1: return {16'h0, rd1_2};
            D2+RD2: return {16'h0, rd2_2};
            D2+B1:  return {31'h0, b1_2};
            D2+B2:  return {31'h0, b2_2};
            D2+BV:  return {16'h0, bv_2};
            default: return 32'hDEAD_DEAD;
        endcase
    endfunction

    // Monitor: compares every expectation due in the current cycle, away from the rising edge
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc == cyc_cnt) begin
            sb_entry_t e;
            logic [31:0] act;
            e = sb.pop_front();
            act = get_actual(e.sel);
            checks++;
            if (act !== e.exp) begin
                errors++;
                $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", e.name, act, e.exp, e.cyc);
            end
        end
    end

    task automatic chk(input int sel, input logic [31:0] exp, input string name);
        sb_entry_t e;
        e.cyc  = cyc_cnt;
        e.sel  = sel;
        e.exp  = exp;
        e.name = name;
        sb.push_back(e);
    endtask

    task automatic drive(input logic we, input logic [3:0] wa, input logic [15:0] wd,
                         input logic [3:0] a1, input logic [3:0] a2,
                         input logic ce, input logic [3:0] ca);
        @(posedge clk);
        #1;
        wr_en      = we;
        wr_addr    = wa;
        wr_data    = wd;
        rd_addr1   = a1;
        rd_addr2   = a2;
        claim_en   = ce;
        claim_addr = ca;
    endtask

    initial begin
        // Write and claim while in reset: both are ignored and reads are masked
        drive(1, 4'd5, 16'h1111, 4'd5, 4'd5, 1, 4'd5);
        chk(D0+RD1, 32'h0, "rst_rd1_masked");
        chk(D0+B1,  32'h0, "rst_busy1_masked");
        chk(D0+BV,  32'h0, "rst_busy_vec");
        drive(0, 4'd0, 16'h0, 4'd5, 4'd5, 0, 4'd0);
        rst = 1'b0;
        chk(D0+RD1, 32'h0, "rst_write_discarded");
        chk(D0+BV,  32'h0, "rst_claim_discarded");

        // Write 0xBEEF to r5, which is forwarded only when bypass is on
        drive(1, 4'd5, 16'hBEEF, 4'd5, 4'd5, 0, 4'd0);
        chk(D0+RD1, 32'hBEEF, "byp_rd1_r5");
        chk(D1+RD1, 32'h0,    "nobyp_rd1_r5_old");
        chk(D2+RD2, 32'hBEEF, "zr_byp_rd2_r5");
        drive(0, 4'd0, 16'h0, 4'd5, 4'd5, 0, 4'd0);
        chk(D0+RD1, 32'hBEEF, "r5_rd1");
        chk(D0+RD2, 32'hBEEF, "r5_rd2");
        chk(D1+RD1, 32'hBEEF, "nobyp_r5_rd1");
        drive(0, 4'd0, 16'h0, 4'd4, 4'd6, 0, 4'd0);
        chk(D0+RD1, 32'h0, "r4_untouched");
        chk(D0+RD2, 32'h0, "r6_untouched");

        // Forwarding of 0x1234 to r3
        drive(1, 4'd3, 16'h1234, 4'd3, 4'd5, 0, 4'd0);
        chk(D0+RD1, 32'h1234, "byp_r3");
        chk(D1+RD1, 32'h0,    "nobyp_r3_old");
        chk(D1+RD2, 32'hBEEF, "nobyp_r5_other_port");
        drive(0, 4'd0, 16'h0, 4'd3, 4'd3, 0, 4'd0);
        chk(D1+RD1, 32'h1234, "nobyp_r3_after_edge");

        // Claim r7, then the write to r7 clears the pending bit
        drive(0, 4'd0, 16'h0, 4'd7, 4'd7, 1, 4'd7);
        chk(D0+B2, 32'h0, "claim_not_yet_visible");
        drive(0, 4'd0, 16'h0, 4'd7, 4'd7, 0, 4'd0);
        chk(D0+B2, 32'h1,    "busy2_r7");
        chk(D0+BV, 32'h0080, "busy_vec_r7");
        chk(D1+B2, 32'h1,    "nobyp_busy2_r7");
        drive(1, 4'd7, 16'h00AA, 4'd7, 4'd7, 0, 4'd0);
        chk(D0+B2,  32'h0,    "byp_busy2_cleared");
        chk(D0+RD2, 32'h00AA, "byp_rd2_r7");
        chk(D1+B2,  32'h1,    "nobyp_busy2_still");
        chk(D1+RD2, 32'h0,    "nobyp_rd2_r7_old");
        chk(D0+BV,  32'h0080, "busy_vec_before_edge");
        drive(0, 4'd0, 16'h0, 4'd7, 4'd7, 0, 4'd0);
        chk(D0+BV,  32'h0,    "busy_vec_r7_cleared");
        chk(D1+RD2, 32'h00AA, "nobyp_r7_written");

        // Claim and write r9 in the same cycle, so the claim wins
        drive(1, 4'd9, 16'h5555, 4'd9, 4'd9, 1, 4'd9);
        chk(D0+RD1, 32'h5555, "byp_r9");
        chk(D0+B1,  32'h0,    "byp_busy1_r9");
        chk(D1+RD1, 32'h0,    "nobyp_r9_old");
        drive(0, 4'd0, 16'h0, 4'd9, 4'd9, 0, 4'd0);
        chk(D0+RD1, 32'h5555, "r9_written");
        chk(D0+B1,  32'h1,    "r9_claim_wins");
        chk(D0+BV,  32'h0200, "busy_vec_r9");

        // Claim r2 and write r9 in the same cycle, so both take effect
        drive(1, 4'd9, 16'h6666, 4'd2, 4'd9, 1, 4'd2);
        chk(D0+RD2, 32'h6666, "byp_r9_new");
        chk(D0+B2,  32'h0,    "byp_busy2_r9");
        chk(D1+RD2, 32'h5555, "nobyp_r9_prev");
        chk(D1+B2,  32'h1,    "nobyp_busy2_r9");
        drive(0, 4'd0, 16'h0, 4'd2, 4'd9, 0, 4'd0);
        chk(D0+B1,  32'h1,    "busy1_r2");
        chk(D0+B2,  32'h0,    "busy2_r9_cleared");
        chk(D0+RD2, 32'h6666, "r9_updated");
        chk(D0+BV,  32'h0004, "busy_vec_r2_only");

        // Write and claim r0: the zero register ignores both
        drive(1, 4'd0, 16'hFFFF, 4'd0, 4'd0, 1, 4'd0);
        chk(D2+RD1, 32'h0,    "zr_rd1_bypass_zero");
        chk(D2+B1,  32'h0,    "zr_busy1_zero");
        chk(D0+RD1, 32'hFFFF, "r0_byp_normal");
        drive(0, 4'd0, 16'h0, 4'd0, 4'd0, 0, 4'd0);
        chk(D2+RD1, 32'h0,    "zr_rd1_after");
        chk(D2+BV,  32'h0004, "zr_busy_vec0_clear");
        chk(D0+RD1, 32'hFFFF, "r0_normal_written");
        chk(D0+BV,  32'h0005, "r0_normal_claimed");

        // Fill r1..r15 with distinct values, then reset between edges
        for (int i = 1; i < 16; i++) begin
            drive(1, 4'(i), 16'(i * 273), 4'd0, 4'd0, 0, 4'd0);
        end
        drive(0, 4'd0, 16'h0, 4'd15, 4'd5, 0, 4'd0);
        chk(D0+RD1, 32'h0FFF, "fill_r15");
        chk(D0+RD2, 32'h0555, "fill_r5");
        chk(D0+BV,  32'h0001, "fill_busy_vec");
        drive(1, 4'd4, 16'hABCD, 4'd15, 4'd5, 1, 4'd4);
        rst = 1'b1;
        chk(D0+RD1, 32'h0, "async_rst_rd1");
        chk(D0+RD2, 32'h0, "async_rst_rd2");
        chk(D0+BV,  32'h0, "async_rst_busy_vec");
        chk(D1+RD1, 32'h0, "async_rst_nobyp_rd1");
        drive(0, 4'd0, 16'h0, 4'd0, 4'd0, 0, 4'd0);
        rst = 1'b0;
        for (int a = 0; a < 16; a++) begin
            drive(0, 4'd0, 16'h0, 4'(a), 4'(15 - a), 0, 4'd0);
            chk(D0+RD1, 32'h0, $sformatf("post_rst_r%0d", a));
            chk(D1+RD2, 32'h0, $sformatf("post_rst_nobyp_r%0d", 15 - a));
        end
        chk(D0+BV, 32'h0, "post_rst_busy_vec");

        // The first edge after reset release is effective
        drive(1, 4'd6, 16'h7777, 4'd6, 4'd6, 1, 4'd1);
        drive(0, 4'd0, 16'h0, 4'd6, 4'd1, 0, 4'd0);
        chk(D1+RD1, 32'h7777, "post_rst_write_r6");
        chk(D1+B2,  32'h1,    "post_rst_claim_r1");
        chk(D1+BV,  32'h0002, "post_rst_busy_vec");

        @(posedge clk);
        @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            $display("FAIL scoreboard_drain: got %0d pending entries, expected 0", sb.size());
            errors += sb.size();
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
